// File: rtl/wheel_pwm_decoder.sv
// Wheel PWM receive decoder: measures high time and period of one PWM line and
// recovers the 6-bit speed code; a line with no edges is reported through a timeout.
module wheel_pwm_decoder #(
    parameter int LOG2_PERIOD     = 10,
    parameter int PERIOD_TOL      = 4,
    parameter int TIMEOUT_PERIODS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pwm_in,
    output logic [5:0]             speed_out,
    output logic [LOG2_PERIOD:0]   high_cycles,
    output logic [LOG2_PERIOD:0]   period_cycles,
    // meas_valid is a one-cycle strobe with no back-pressure: the result outputs change
    // only in a strobe cycle and hold their value until the next strobe.
    output logic                   meas_valid,
    output logic                   period_err,
    output logic                   stale,
    output logic [1:0]             fsm_state
);

    localparam int CW = LOG2_PERIOD + 1;
    localparam logic [CW-1:0] NOMINAL = CW'(2 ** LOG2_PERIOD);
    localparam logic [CW-1:0] TOL     = CW'(PERIOD_TOL);
    localparam int IDLE_T = TIMEOUT_PERIODS * (2 ** LOG2_PERIOD);
    localparam int IW     = $clog2(IDLE_T + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_T);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_T - 1);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          meta;
    logic          s;
    logic          s_d;
    logic [1:0]    warm;
    logic          edge_ok;
    logic          rise;
    logic          fall;
    logic          timeout;
    logic          publish;
    logic [CW-1:0] hi_cnt;
    logic [CW-1:0] hi_next;
    logic [CW-1:0] per_cnt;
    logic [CW-1:0] per_next;
    logic [CW-1:0] per_diff;
    logic [IW-1:0] idle_cnt;
    logic [IW-1:0] idle_next;
    logic [5:0]    speed_next;
    logic [CW-1:0] high_next;
    logic [CW-1:0] period_next;
    logic          valid_next;
    logic          err_next;
    logic          stale_next;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // The synchronizer clears on reset, so edges are ignored until s_d holds a real
    // sample; otherwise a line that is high through reset would look like a fresh rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
            warm <= 2'd0;
        end else begin
            meta <= pwm_in;
            s    <= meta;
            s_d  <= s;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    always_comb begin
        edge_ok = (warm == 2'd3);
        rise    = edge_ok & s & ~s_d;
        fall    = edge_ok & ~s & s_d;
        // A rise in the same cycle wins over an expiring timeout.
        timeout = ~rise & ~fall & (idle_cnt == IDLE_LAST);
        if (rise | fall) begin
            idle_next = '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_next = idle_cnt + IW'(1);
        end else begin
            idle_next = idle_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        hi_next    = hi_cnt;
        per_next   = per_cnt;
        publish    = 1'b0;
        case (state)
            ST_SYNC: begin
                if (rise) begin
                    state_next = ST_HIGH;
                    hi_next    = CW'(1);
                    per_next   = CW'(1);
                end
            end
            ST_HIGH: begin
                per_next = sat_inc(per_cnt);
                if (fall) begin
                    state_next = ST_LOW;
                end else begin
                    hi_next = sat_inc(hi_cnt);
                end
            end
            ST_LOW: begin
                if (rise) begin
                    publish    = 1'b1;
                    state_next = ST_HIGH;
                    hi_next    = CW'(1);
                    per_next   = CW'(1);
                end else begin
                    per_next = sat_inc(per_cnt);
                end
            end
            default: begin
                state_next = ST_SYNC;
            end
        endcase
        if (timeout) begin
            state_next = ST_SYNC;
        end
    end

    always_comb begin
        per_diff    = (per_cnt >= NOMINAL) ? (per_cnt - NOMINAL) : (NOMINAL - per_cnt);
        speed_next  = speed_out;
        high_next   = high_cycles;
        period_next = period_cycles;
        err_next    = period_err;
        stale_next  = stale;
        valid_next  = 1'b0;
        if (publish) begin
            // Truncating scale to 64 steps; anything at or above one full period is max speed.
            speed_next  = hi_cnt[CW-1] ? 6'd63 : hi_cnt[LOG2_PERIOD-1 -: 6];
            high_next   = hi_cnt;
            period_next = per_cnt;
            err_next    = (per_diff > TOL);
            stale_next  = 1'b0;
            valid_next  = 1'b1;
        end else if (timeout) begin
            speed_next = s ? 6'd63 : 6'd0;
            stale_next = 1'b1;
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_cnt        <= '0;
            per_cnt       <= '0;
            idle_cnt      <= '0;
            speed_out     <= '0;
            high_cycles   <= '0;
            period_cycles <= '0;
            meas_valid    <= 1'b0;
            period_err    <= 1'b0;
            stale         <= 1'b0;
        end else begin
            hi_cnt        <= hi_next;
            per_cnt       <= per_next;
            idle_cnt      <= idle_next;
            speed_out     <= speed_next;
            high_cycles   <= high_next;
            period_cycles <= period_next;
            meas_valid    <= valid_next;
            period_err    <= err_next;
            stale         <= stale_next;
        end
    end

    assign fsm_state = state;

endmodule
